elevator_ctrl: RTL

Parametrised elevator controller for an N-floor car. Latches floor calls into a pending register and serves them with a directional sweep: the car keeps moving one way while calls remain ahead of it, then reverses. It sequences door dwell, safety interlock (overweight / jammed door), motor and brake, and tracks the current floor. It sits between the debounced call/sensor inputs and the motor, brake, door and 7-segment display drivers.

---
 rtl/elevator_pkg.sv | 60 ++++++
 rtl/elevator_if.sv | 35 +++
 rtl/elevator_timer.sv | 38 +++
 rtl/elevator_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elevator_pkg
// Description : Shared types, output-decode constants and call-search helpers
//               for the elevator controller.
// Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    // Upper bound on car size; the helpers work on vectors of this width
    localparam int c_max_floors  = 16;
    localparam int c_max_floor_w = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DOOR_OPEN = 2'd1,
        SAFETY    = 2'd2,
        MOVE      = 2'd3
    } state_t;

    // Actuator drive word: {motor, brake, open_door}
    typedef struct packed {
        logic motor;
        logic brake;
        logic open_door;
    } drive_t;

    localparam drive_t c_drive_idle   = 3'b010;
    localparam drive_t c_drive_door   = 3'b011;
    localparam drive_t c_drive_safety = 3'b010;
    localparam drive_t c_drive_move   = 3'b100;

    // True when any call is registered strictly above the given floor
    function automatic logic calls_above(input logic [c_max_floors-1:0]  pend,
                                         input logic [c_max_floor_w-1:0] floor);
        logic found;
        found = 1'b0;
        for (int i = 0; i < c_max_floors; i++) begin
            if ((i > int'(floor)) && pend[i]) begin
                found = 1'b1;
            end
        end
        return found;
    endfunction

    // True when any call is registered strictly below the given floor
    function automatic logic calls_below(input logic [c_max_floors-1:0]  pend,
                                         input logic [c_max_floor_w-1:0] floor);
        logic found;
        found = 1'b0;
        for (int i = 0; i < c_max_floors; i++) begin
            if ((i < int'(floor)) && pend[i]) begin
                found = 1'b1;
            end
        end
        return found;
    endfunction

endpackage
`default_nettype wire

// File: rtl/elevator_if.sv
`default_nettype none
// ============================================================================
// Module      : elevator_if
// Description : Call/sensor inputs and actuator/status outputs of the
//               elevator controller. slave = controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface elevator_if #(
    parameter int NUM_FLOORS = 5
);
    localparam int FLOOR_W = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;

    logic [NUM_FLOORS-1:0] call_req;
    logic                  overweight;
    logic                  jammed_door;
    logic                  motor;
    logic                  brake;
    logic                  open_door;
    logic                  dir_up;
    logic [FLOOR_W-1:0]    cur_floor;
    logic [1:0]            state;
    logic [NUM_FLOORS-1:0] pending;

    modport slave (
        input  call_req, overweight, jammed_door,
        output motor, brake, open_door, dir_up, cur_floor, state, pending
    );

    modport master (
        output call_req, overweight, jammed_door,
        input  motor, brake, open_door, dir_up, cur_floor, state, pending
    );

endinterface
`default_nettype wire

// File: rtl/elevator_timer.sv
`default_nettype none
// ============================================================================
// Module      : elevator_timer
// Description : Loadable down-counter with enable and zero flag, used for the
//               door dwell and the per-floor travel time.
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_timer #(
    parameter int WIDTH  = 8,
    parameter int RELOAD = 1
) (
    input  wire  clk,
    input  wire  reset,
    input  wire  i_load,
    input  wire  i_en,
    output logic o_zero
);

    localparam logic [WIDTH-1:0] c_reload = WIDTH'(RELOAD);
    localparam logic [WIDTH-1:0] c_one    = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    // Load has priority over counting down
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= c_reload;
        end else if (i_en) begin
            r_count <= r_count - c_one;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/elevator_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : elevator_ctrl
// Description : N-floor elevator controller: pending-call register, sweep
//               direction logic, door/safety/motor sequencing, floor counter.
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 5,
    parameter int DOOR_CYCLES   = 100,
    parameter int TRAVEL_CYCLES = 200
) (
    input  wire       clk,
    input  wire       reset,
    elevator_if.slave bus
);

    localparam int FLOOR_W  = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
    localparam int DOOR_W   = $clog2(DOOR_CYCLES);
    localparam int TRAVEL_W = $clog2(TRAVEL_CYCLES);

    localparam logic [FLOOR_W-1:0]    c_floor_one = FLOOR_W'(1);
    localparam logic [FLOOR_W-1:0]    c_top_floor = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [NUM_FLOORS-1:0] c_floor_bit = NUM_FLOORS'(1);

    state_t                r_state, w_next_state;
    logic [NUM_FLOORS-1:0] r_pending, w_serve;
    logic [FLOOR_W-1:0]    r_cur_floor, w_next_floor, w_step_floor;
    logic                  r_dir_up, w_next_dir_up;

    logic [c_max_floors-1:0] w_pend_ext;
    logic w_hazard, w_any_pending, w_ahead, w_behind, w_ahead_at_step, w_at_bound;
    logic w_enter_door;
    logic w_door_load, w_door_en, w_door_zero;
    logic w_travel_load, w_travel_en, w_travel_zero;
    drive_t w_drive;

    assign w_hazard      = bus.overweight | bus.jammed_door;
    assign w_any_pending = |r_pending;
    assign w_pend_ext    = c_max_floors'(r_pending);

    // Search ahead / behind relative to the current sweep direction
    assign w_ahead  = r_dir_up ? calls_above(w_pend_ext, c_max_floor_w'(r_cur_floor))
                               : calls_below(w_pend_ext, c_max_floor_w'(r_cur_floor));
    assign w_behind = r_dir_up ? calls_below(w_pend_ext, c_max_floor_w'(r_cur_floor))
                               : calls_above(w_pend_ext, c_max_floor_w'(r_cur_floor));

    assign w_step_floor    = r_dir_up ? (r_cur_floor + c_floor_one) : (r_cur_floor - c_floor_one);
    assign w_at_bound      = r_dir_up ? (r_cur_floor == c_top_floor) : (r_cur_floor == '0);
    assign w_ahead_at_step = r_dir_up ? calls_above(w_pend_ext, c_max_floor_w'(w_step_floor))
                                      : calls_below(w_pend_ext, c_max_floor_w'(w_step_floor));

    // Next-state, floor step and direction decisions
    always_comb begin
        w_next_state  = r_state;
        w_next_floor  = r_cur_floor;
        w_next_dir_up = r_dir_up;
        w_travel_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pending[r_cur_floor]) begin
                    w_next_state = DOOR_OPEN;
                end else if (w_any_pending) begin
                    w_next_state = SAFETY;
                end
            end
            DOOR_OPEN: begin
                if (!w_hazard && w_door_zero) begin
                    w_next_state = w_any_pending ? SAFETY : IDLE;
                end
            end
            SAFETY: begin
                if (w_hazard) begin
                    w_next_state = DOOR_OPEN;
                end else if (w_ahead) begin
                    w_next_state  = MOVE;
                    w_travel_load = 1'b1;
                end else if (w_behind) begin
                    w_next_state  = MOVE;
                    w_next_dir_up = ~r_dir_up;
                    w_travel_load = 1'b1;
                end else if (r_pending[r_cur_floor]) begin
                    w_next_state = DOOR_OPEN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            MOVE: begin
                if (w_travel_zero) begin
                    if (w_at_bound) begin
                        // Never expected: re-evaluate rather than leave the shaft
                        w_next_state = SAFETY;
                    end else begin
                        w_next_floor = w_step_floor;
                        if (r_pending[w_step_floor]) begin
                            w_next_state = DOOR_OPEN;
                        end else if (!w_ahead_at_step) begin
                            w_next_state = SAFETY;
                        end else begin
                            w_travel_load = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // A call is served on the edge the car enters DOOR_OPEN at its floor
    assign w_enter_door = (w_next_state == DOOR_OPEN) && (r_state != DOOR_OPEN);
    assign w_serve      = w_enter_door ? (c_floor_bit << w_next_floor) : '0;

    assign w_door_load  = w_enter_door || ((r_state == DOOR_OPEN) && w_hazard);
    assign w_door_en    = (r_state == DOOR_OPEN) && !w_hazard && !w_door_zero;
    assign w_travel_en  = (r_state == MOVE) && !w_travel_zero;

    elevator_timer #(
        .WIDTH  (DOOR_W),
        .RELOAD (DOOR_CYCLES - 1)
    ) u_door_timer (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_door_load),
        .i_en   (w_door_en),
        .o_zero (w_door_zero)
    );

    elevator_timer #(
        .WIDTH  (TRAVEL_W),
        .RELOAD (TRAVEL_CYCLES - 1)
    ) u_travel_timer (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_travel_load),
        .i_en   (w_travel_en),
        .o_zero (w_travel_zero)
    );

    // State, floor, direction and pending registers; clear beats set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cur_floor <= '0;
            r_dir_up    <= 1'b1;
            r_pending   <= '0;
        end else begin
            r_state     <= w_next_state;
            r_cur_floor <= w_next_floor;
            r_dir_up    <= w_next_dir_up;
            r_pending   <= (r_pending | bus.call_req) & ~w_serve;
        end
    end

    // A floor step out of the shaft must be unreachable
    always_ff @(posedge clk) begin
        if (reset && (r_state == MOVE) && w_travel_zero) begin
            assert (!w_at_bound);
        end
    end

    // Moore decode of the actuator outputs
    always_comb begin
        w_drive = c_drive_idle;
        case (r_state)
            DOOR_OPEN: w_drive = c_drive_door;
            SAFETY:    w_drive = c_drive_safety;
            MOVE:      w_drive = c_drive_move;
            default:   w_drive = c_drive_idle;
        endcase
    end

    assign bus.motor     = w_drive.motor;
    assign bus.brake     = w_drive.brake;
    assign bus.open_door = w_drive.open_door;
    assign bus.dir_up    = r_dir_up;
    assign bus.cur_floor = r_cur_floor;
    assign bus.state     = r_state;
    assign bus.pending   = r_pending;

endmodule
`default_nettype wire
